// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a 1-cycle-latency ROM from an internal PC
// and queues returned words, tagged with their PC, for the decode stage.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic                       rom_en,
    input  logic [DATA_W-1:0]          rom_data,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       br_valid,
    input  logic [ADDR_W-1:0]          br_target,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;
    logic              r_inflight;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_pcs  [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_room;
    logic          w_issue;
    logic [CW:0]   w_need;

    assign instr_valid = (r_count != '0);
    assign fifo_count  = r_count;
    assign instr       = r_data[r_rptr];
    assign instr_pc    = r_pcs[r_rptr];

    assign w_pop  = instr_valid & instr_ready;
    // A branch flushes the queue, so the returning word is dropped here
    assign w_push = r_inflight & ~br_valid;

    // Occupancy including the word still in flight from the ROM
    assign w_need = {1'b0, r_count} + {{CW{1'b0}}, r_inflight}
                  - {{CW{1'b0}}, w_pop};
    assign w_room = br_valid | (w_need < (CW+1)'(DEPTH));

    assign w_issue  = en & w_room & ~rst;
    assign rom_en   = w_issue;
    assign rom_addr = br_valid ? br_target : r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= ADDR_W'(RESET_PC);
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_pc       <= w_issue ? rom_addr + ADDR_W'(1) : rom_addr;
            r_inflight <= w_issue;
            if (w_issue)
                r_tag <= rom_addr;
            if (br_valid) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + PW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= rom_data;
            r_pcs[r_wptr]  <= r_tag;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, backpressure, branch, wrap, reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        instr_ready;
    logic        br_valid;
    logic [7:0]  br_target;

    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic [1:0]  fifo_count;

    logic [7:0]  w_rom_addr;
    logic        w_rom_en;
    logic [15:0] w_rom_data;
    logic [15:0] w_instr;
    logic [7:0]  w_instr_pc;
    logic        w_instr_valid;
    logic [1:0]  w_fifo_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .br_valid(br_valid),
        .br_target(br_target), .fifo_count(fifo_count)
    );

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'hFE), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst), .en(en),
        .rom_addr(w_rom_addr), .rom_en(w_rom_en), .rom_data(w_rom_data),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
        .instr_ready(1'b1), .br_valid(1'b0),
        .br_target(8'h00), .fifo_count(w_fifo_count)
    );

    // ROM model: ROM[i] = A000 + i, one-cycle read latency
    always_ff @(posedge clk) begin
        if (rom_en)
            rom_data <= 16'hA000 + {8'h00, rom_addr};
        if (w_rom_en)
            w_rom_data <= 16'hA000 + {8'h00, w_rom_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_instr"}, 32'(instr), 32'hA000 + 32'(pc));
        chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; instr_ready = 1'b0;
        br_valid = 1'b0; br_target = 8'h00;

        // reset state
        @(negedge clk); #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);

        // stream: cycle 0 issues PC 0
        @(negedge clk);
        rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
        #1;
        chk("c0_rom_en", 32'(rom_en), 32'd1);
        chk("c0_addr", 32'(rom_addr), 32'h00);
        chk("c0_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); #1;
        chk("c1_valid", 32'(instr_valid), 32'd0);
        chk("c1_addr", 32'(rom_addr), 32'h01);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk); #1;
            head("stream", 8'(k - 2));
            if (k <= 5) begin
                chk("wrap_valid", 32'(w_instr_valid), 32'd1);
                chk("wrap_pc", 32'(w_instr_pc), 32'(8'(8'hFE + 8'(k - 2))));
                chk("wrap_instr", 32'(w_instr),
                    32'hA000 + 32'(8'(8'hFE + 8'(k - 2))));
            end
        end

        // backpressure: five stalled cycles, head 6 held
        for (int k = 8; k <= 12; k++) begin
            @(negedge clk);
            instr_ready = 1'b0;
            #1;
            head("stall", 8'h06);
            chk("stall_rom_en", 32'(rom_en), 32'd0);
            if (k >= 9)
                chk("stall_full", 32'(fifo_count), 32'd2);
        end
        @(negedge clk);
        instr_ready = 1'b1;
        #1;
        head("release", 8'h06);
        chk("release_rom_en", 32'(rom_en), 32'd1);
        chk("release_addr", 32'(rom_addr), 32'h08);
        for (int k = 7; k <= 9; k++) begin
            @(negedge clk); #1;
            head("resume", 8'(k));
        end

        // branch while a word is queued and one is in flight
        @(negedge clk);
        instr_ready = 1'b0; br_valid = 1'b1; br_target = 8'h40;
        #1;
        head("br_head", 8'h0A);
        chk("br_rom_en", 32'(rom_en), 32'd1);
        chk("br_addr", 32'(rom_addr), 32'h40);
        @(negedge clk);
        br_valid = 1'b0; instr_ready = 1'b1;
        #1;
        chk("br1_valid", 32'(instr_valid), 32'd0);
        chk("br1_count", 32'(fifo_count), 32'd0);
        chk("br1_addr", 32'(rom_addr), 32'h41);
        @(negedge clk); #1;
        head("br2", 8'h40);
        @(negedge clk); #1;
        head("br3", 8'h41);

        // branch with pop: head 0x42 consumed once
        @(negedge clk);
        br_valid = 1'b1; br_target = 8'h80;
        #1;
        head("bp_head", 8'h42);
        @(negedge clk);
        br_valid = 1'b0;
        #1;
        chk("bp1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); #1;
        head("bp2", 8'h80);
        @(negedge clk); #1;
        head("bp3", 8'h81);

        // branch with pop and en=0: resumes at target later
        @(negedge clk);
        br_valid = 1'b1; br_target = 8'h20; en = 1'b0;
        #1;
        head("be_head", 8'h82);
        chk("be_rom_en", 32'(rom_en), 32'd0);
        @(negedge clk);
        br_valid = 1'b0;
        #1;
        chk("be1_valid", 32'(instr_valid), 32'd0);
        chk("be1_rom_en", 32'(rom_en), 32'd0);
        chk("be1_addr", 32'(rom_addr), 32'h20);
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("be2_rom_en", 32'(rom_en), 32'd1);
        chk("be2_addr", 32'(rom_addr), 32'h20);
        @(negedge clk); #1;
        chk("be3_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); #1;
        head("be4", 8'h20);
        @(negedge clk); #1;
        head("be5", 8'h21);

        // reset with a word queued and a fetch in flight
        @(negedge clk);
        rst = 1'b1; instr_ready = 1'b0;
        #1;
        chk("mr_rom_en", 32'(rom_en), 32'd0);
        chk("mr_count_pre", 32'(fifo_count), 32'd1);
        @(negedge clk);
        rst = 1'b0; instr_ready = 1'b1;
        #1;
        chk("mr1_valid", 32'(instr_valid), 32'd0);
        chk("mr1_count", 32'(fifo_count), 32'd0);
        chk("mr1_addr", 32'(rom_addr), 32'h00);
        @(negedge clk); #1;
        chk("mr2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); #1;
        head("mr3", 8'h00);
        @(negedge clk); #1;
        head("mr4", 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
